// File: rtl/bufba_pipe.sv
// bufba_pipe: DEPTH-entry valid/ready elastic buffer with registered storage.
// Define BUFBA_PIPE_BYPASS_EN to forward A straight to Z when the buffer is empty.
module bufba_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic             AV,
    output logic             AR,
    output logic [WIDTH-1:0] Z,
    output logic             ZV,
    input  logic             ZR,
    output logic [CW-1:0]    CNT
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic empty, wr, rd;
    assign empty = CNT == '0;
    assign AR = (CNT != CW'(DEPTH)) && !RST;
    assign rd = !empty && ZR;
`ifdef BUFBA_PIPE_BYPASS_EN
    logic byp;
    assign byp = empty && AV && AR;
    assign ZV = !empty || byp;
    assign Z = byp ? A : mem[rp];
    // a word taken straight through while empty never touches storage
    assign wr = AV && AR && !(empty && ZR);
`else
    assign ZV = !empty;
    assign Z = mem[rp];
    assign wr = AV && AR;
`endif
    always_ff @(posedge CLK) begin
        if (RST) begin
            wp <= '0;
            rp <= '0;
            CNT <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= A;
                wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
            end
            if (rd) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
            CNT <= CNT + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: tb/tb_bufba_pipe.sv
// tb_bufba_pipe: bufba_pipe at DEPTH=4 and DEPTH=5 against a queue reference model.
module tb_bufba_pipe;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic [7:0] a [2];
    logic [7:0] z [2];
    logic       av [2];
    logic       zr [2];
    logic       ar [2];
    logic       zv [2];
    logic [2:0] cnt [2];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bufba_pipe #(.WIDTH(8), .DEPTH(4)) u4 (
        .CLK(clk), .RST(rst), .A(a[0]), .AV(av[0]), .AR(ar[0]),
        .Z(z[0]), .ZV(zv[0]), .ZR(zr[0]), .CNT(cnt[0])
    );
    bufba_pipe #(.WIDTH(8), .DEPTH(5)) u5 (
        .CLK(clk), .RST(rst), .A(a[1]), .AV(av[1]), .AR(ar[1]),
        .Z(z[1]), .ZV(zv[1]), .ZR(zr[1]), .CNT(cnt[1])
    );

    // reference: an ordered queue of stored words per lane
    for (genvar g = 0; g < 2; g++) begin : m
        localparam int D = g ? 5 : 4;
        logic [7:0] q[$];
        always @(negedge clk) begin
            bit ear, ezv;
            logic [7:0] ez;
            ear = !rst && q.size() != D;
            ezv = q.size() != 0;
            ez = ezv ? q[0] : 8'h00;
`ifdef BUFBA_PIPE_BYPASS_EN
            if (q.size() == 0 && av[g] && ear) begin
                ezv = 1;
                ez = a[g];
            end
`endif
            chk("m_ar", 32'(ar[g]), 32'(ear));
            chk("m_zv", 32'(zv[g]), 32'(ezv));
            chk("m_cnt", 32'(cnt[g]), q.size());
            if (ezv) chk("m_z", 32'(z[g]), 32'(ez));
        end
        always @(posedge clk) begin
            bit ear, pu, po;
            ear = !rst && q.size() != D;
            pu = av[g] && ear;
            po = q.size() != 0 && zr[g];
            if (rst) q.delete();
`ifdef BUFBA_PIPE_BYPASS_EN
            else if (q.size() == 0 && pu && zr[g]) begin end
`endif
            else begin
                if (po) void'(q.pop_front());
                if (pu) q.push_back(a[g]);
            end
        end
    end

    logic [7:0] data [13];
    initial begin
        int sent, got, cyc;
        bit acc;
        void'($urandom(32'd42));
        a = '{8'h00, 8'h00};
        av = '{1'b0, 1'b0};
        zr = '{1'b0, 1'b0};
        // reset held with a valid word presented
        a[0] = 8'hA5;
        av[0] = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ar", 32'(ar[0]), 0);
            chk("rst_zv", 32'(zv[0]), 0);
            chk("rst_z", 32'(z[0]), 0);
            chk("rst_cnt", 32'(cnt[0]), 0);
        end
        @(posedge clk);
        #1;
        rst = 0;
        av[0] = 0;
        #1;
        chk("rel_ar", 32'(ar[0]), 1);
        chk("rel_cnt", 32'(cnt[0]), 0);
        step();
        chk("rel_empty", 32'(cnt[0]), 0);
        // fill to full
        for (int i = 0; i < 4; i++) begin
            a[0] = 8'(8'h11 * (i + 1));
            av[0] = 1;
            step();
            chk("fill_cnt", 32'(cnt[0]), i + 1);
        end
        chk("full_ar", 32'(ar[0]), 0);
        a[0] = 8'h55;
        step();
        chk("full_hold", 32'(cnt[0]), 4);
        chk("full_z", 32'(z[0]), 8'h11);
        zr[0] = 1;
        step();
        chk("reopen_ar", 32'(ar[0]), 1);
        chk("drain_z", 32'(z[0]), 8'h22);
        step();
        chk("drain_z", 32'(z[0]), 8'h33);
        chk("drain_cnt", 32'(cnt[0]), 3);
        av[0] = 0;
        step();
        chk("drain_z", 32'(z[0]), 8'h44);
        step();
        chk("drain_z", 32'(z[0]), 8'h55);
        step();
        chk("drain_zv", 32'(zv[0]), 0);
        // concurrent push/pop at CNT=2
        zr[0] = 0;
        for (int i = 0; i < 2; i++) begin
            a[0] = 8'(i);
            av[0] = 1;
            step();
        end
        zr[0] = 1;
        for (int k = 1; k <= 20; k++) begin
            a[0] = 8'(k + 1);
            step();
            chk("str_cnt", 32'(cnt[0]), 2);
            chk("str_z", 32'(z[0]), k);
        end
        av[0] = 0;
        step();
        step();
        chk("str_empty", 32'(cnt[0]), 0);
        zr[0] = 0;
        // DEPTH=5 wrap under random stalls
        sent = 0;
        got = 0;
        cyc = 0;
        for (int i = 0; i < 13; i++) data[i] = 8'($urandom);
        while (got < 13 && cyc < 400) begin
            if (!av[1] && sent < 13 && $urandom_range(0, 2) != 0) begin
                a[1] = data[sent];
                av[1] = 1;
            end
            zr[1] = 1'($urandom_range(0, 1));
            #1;
            acc = av[1] && ar[1];
            if (zv[1] && zr[1]) begin
                chk("wrap_ord", 32'(z[1]), 32'(data[got]));
                got++;
            end
            step();
            if (acc) begin
                sent++;
                av[1] = 0;
            end
            cyc++;
        end
        chk("wrap_done", got, 13);
        av[1] = 0;
        zr[1] = 0;
        // reset mid-stream at CNT=3
        for (int i = 0; i < 3; i++) begin
            a[0] = 8'(8'hC0 + i);
            av[0] = 1;
            step();
        end
        av[0] = 0;
        chk("mid_cnt", 32'(cnt[0]), 3);
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_cnt", 32'(cnt[0]), 0);
        chk("mid_rst_zv", 32'(zv[0]), 0);
        zr[0] = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_stale", 32'(zv[0]), 0);
        end
        // empty buffer, word presented with consumer ready
        a[0] = 8'h7E;
        av[0] = 1;
        #1;
`ifdef BUFBA_PIPE_BYPASS_EN
        chk("byp_zv", 32'(zv[0]), 1);
        chk("byp_z", 32'(z[0]), 8'h7E);
        step();
        av[0] = 0;
        #1;
        chk("byp_cnt", 32'(cnt[0]), 0);
        chk("byp_after_zv", 32'(zv[0]), 0);
`else
        chk("nobyp_zv0", 32'(zv[0]), 0);
        step();
        av[0] = 0;
        chk("nobyp_zv", 32'(zv[0]), 1);
        chk("nobyp_z", 32'(z[0]), 8'h7E);
        chk("nobyp_cnt", 32'(cnt[0]), 1);
        step();
        chk("nobyp_pop", 32'(cnt[0]), 0);
`endif
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
